// File: rtl/halut_ctrl_pkg.sv
// Shared types and width helpers for the HALUT decoder controller.
// Optional perf counters in the top are enabled by HALUT_CTRL_PERF_EN.
package halut_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ROW      = 2'd1,
      WAIT_RES = 2'd2
   } halut_ctrl_state_e;

   localparam int unsigned ResultWidth = 32;

   // Address width that never collapses to zero bits.
   function automatic int unsigned addr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned c_addr_w(input int unsigned c);
      return addr_w(c);
   endfunction

   function automatic int unsigned tree_depth(input int unsigned k);
      return addr_w(k);
   endfunction

   function automatic int unsigned total_addr_w(input int unsigned c,
                                                input int unsigned k);
      return addr_w(c * k);
   endfunction

endpackage

// File: rtl/halut_result_fifo.sv
// Small circular result FIFO, 32-bit, registered head, no fall-through.
// Exports its occupancy so the controller can apply a credit check.
module halut_result_fifo
   import halut_ctrl_pkg::*;
#(
   parameter int unsigned Depth = 2,
   parameter int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic [ResultWidth-1:0] data_i,
   input  logic                   pop_i,
   output logic                   valid_o,
   output logic [ResultWidth-1:0] data_o,
   output logic [CntW-1:0]        count_o
);

   localparam int unsigned     PtrW    = addr_w(Depth);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(Depth);

   logic [ResultWidth-1:0] mem_q [Depth];
   logic [PtrW-1:0]        rd_q;
   logic [PtrW-1:0]        wr_q;
   logic [CntW-1:0]        cnt_q;
   logic                   do_push;
   logic                   do_pop;

   assign do_pop  = pop_i && (cnt_q != '0);
   assign do_push = push_i && ((cnt_q != CntFull) || do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= (wr_q == PtrLast) ? '0 : wr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_q <= (rd_q == PtrLast) ? '0 : rd_q + PtrW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CntW'(1);
            2'b01:   cnt_q <= cnt_q - CntW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign valid_o = (cnt_q != '0);
   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/halut_decoder_ctrl.sv
// Row sequencer, LUT-write arbiter and result collector for one HALUT decoder.
// Define HALUT_CTRL_PERF_EN to build the rows/stall performance counters.
module halut_decoder_ctrl
   import halut_ctrl_pkg::*;
#(
   parameter int unsigned C              = 32,
   parameter int unsigned K              = 16,
   parameter int unsigned DataTypeWidth  = 16,
   parameter int unsigned ResFifoDepth   = 2,
   parameter int unsigned TotalAddrWidth = total_addr_w(C, K),
   parameter int unsigned CAddrWidth     = c_addr_w(C),
   parameter int unsigned TreeDepth      = tree_depth(K)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      enc_valid_i,
   output logic                      enc_ready_o,
   input  logic [TreeDepth-1:0]      enc_k_i,
   input  logic                      lut_valid_i,
   output logic                      lut_ready_o,
   input  logic [TotalAddrWidth-1:0] lut_addr_i,
   input  logic [DataTypeWidth-1:0]  lut_data_i,
   output logic [CAddrWidth-1:0]     dec_c_addr_o,
   output logic [TreeDepth-1:0]      dec_k_addr_o,
   output logic                      dec_en_o,
   output logic [TotalAddrWidth-1:0] dec_waddr_o,
   output logic [DataTypeWidth-1:0]  dec_wdata_o,
   output logic                      dec_we_o,
   input  logic [31:0]               dec_result_i,
   input  logic                      dec_valid_i,
   output logic                      res_valid_o,
   input  logic                      res_ready_i,
   output logic [31:0]               res_data_o,
   output logic                      busy_o,
   output logic [31:0]               rows_done_o,
   output logic [31:0]               stall_cycles_o
);

   localparam int unsigned           CntW     = $clog2(ResFifoDepth + 1);
   localparam logic [CAddrWidth-1:0] CLast    = CAddrWidth'(C - 1);
   localparam logic [CntW-1:0]       FifoFull = CntW'(ResFifoDepth);

   halut_ctrl_state_e     state_q;
   logic [CAddrWidth-1:0] c_q;
   logic [CntW-1:0]       fifo_count;
   logic                  at_last;
   logic                  has_credit;
   logic                  lut_grant;
   logic                  enc_hs;
   logic                  res_push;

   assign at_last    = (c_q == CLast);
   assign has_credit = (fifo_count != FifoFull);

   // LUT writes only land between rows and win over a new row start.
   assign lut_ready_o = (state_q == IDLE) && (c_q == '0);
   assign lut_grant   = lut_valid_i && lut_ready_o;

   assign enc_ready_o = (state_q != WAIT_RES) && !lut_grant &&
                        (!at_last || has_credit);
   assign enc_hs      = enc_valid_i && enc_ready_o;
   assign res_push    = dec_valid_i && (state_q == WAIT_RES);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         c_q     <= '0;
      end else begin
         if (enc_hs) begin
            c_q <= at_last ? '0 : c_q + CAddrWidth'(1);
         end
         unique case (state_q)
            IDLE: begin
               if (enc_hs) state_q <= at_last ? WAIT_RES : ROW;
            end
            ROW: begin
               if (enc_hs && at_last) state_q <= WAIT_RES;
            end
            WAIT_RES: begin
               if (dec_valid_i) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dec_c_addr_o = c_q;
   assign dec_k_addr_o = enc_k_i;
   assign dec_en_o     = enc_hs;
   assign dec_waddr_o  = lut_addr_i;
   assign dec_wdata_o  = lut_data_i;
   assign dec_we_o     = lut_grant;

   halut_result_fifo #(
      .Depth (ResFifoDepth),
      .CntW  (CntW)
   ) u_result_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (res_push),
      .data_i  (dec_result_i),
      .pop_i   (res_ready_i),
      .valid_o (res_valid_o),
      .data_o  (res_data_o),
      .count_o (fifo_count)
   );

   assign busy_o = (state_q != IDLE) || (fifo_count != '0);

`ifdef HALUT_CTRL_PERF_EN
   logic [31:0] rows_q;
   logic [31:0] stall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rows_q  <= '0;
         stall_q <= '0;
      end else begin
         if (res_push) rows_q <= rows_q + 32'd1;
         if (enc_valid_i && !enc_ready_o) stall_q <= stall_q + 32'd1;
      end
   end

   assign rows_done_o    = rows_q;
   assign stall_cycles_o = stall_q;
`else
   assign rows_done_o    = '0;
   assign stall_cycles_o = '0;
`endif

   // A decoder result outside WAIT_RES is dropped; flag it as a protocol error.
   a_dec_valid_in_wait : assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      dec_valid_i |-> (state_q == WAIT_RES)
   );

endmodule
